// File: rtl/pht_update_unit.sv
// Update front end for the pattern history table: sweeps the PHT to weakly-not-taken after
// reset, then turns up to two resolved branches per cycle into saturating-counter writes.
module pht_update_unit #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd0_valid_i,
    input  logic [ADDR_W-1:0]       upd0_idx_i,
    input  logic                    upd0_taken_i,
    input  logic [CNT_W-1:0]        upd0_cnt_i,
    input  logic                    upd1_valid_i,
    input  logic [ADDR_W-1:0]       upd1_idx_i,
    input  logic                    upd1_taken_i,
    input  logic [CNT_W-1:0]        upd1_cnt_i,
    output logic                    upd_ready_o,
    output logic                    init_busy_o,
    output logic [ADDR_W+CNT_W:0]   w_obus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  INIT_CNT   = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] sweep;
    logic [ADDR_W-1:0] fifo_idx [DEPTH];
    logic [CNT_W-1:0]  fifo_cnt [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CW-1:0]     count;
    logic              acc0;
    logic              acc1;
    logic              pop;
    logic [CNT_W-1:0]  base0;
    logic [CNT_W-1:0]  base1;
    logic [CNT_W-1:0]  new0;
    logic [CNT_W-1:0]  new1;

    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] b, input logic taken);
        if (taken)
            return (b == CNT_MAX) ? CNT_MAX : b + CNT_W'(1);
        else
            return (b == '0) ? '0 : b - CNT_W'(1);
    endfunction

    // Ready only looks at the registered fill level so a pop never grants credit in the same cycle.
    assign upd_ready_o = (state == RUN) && ((CW'(DEPTH) - count) >= CW'(2));
    assign init_busy_o = (state == INIT);
    assign acc0        = upd0_valid_i && upd_ready_o;
    assign acc1        = upd1_valid_i && upd_ready_o;
    assign pop         = (state == RUN) && (count != '0);

    // Walk queued entries oldest to youngest so the last match is the youngest in-flight value;
    // the head still counts even when it is being written out this cycle.
    always_comb begin
        base0 = upd0_cnt_i;
        base1 = upd1_cnt_i;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (fifo_idx[head + PTR_W'(i)] == upd0_idx_i)
                    base0 = fifo_cnt[head + PTR_W'(i)];
                if (fifo_idx[head + PTR_W'(i)] == upd1_idx_i)
                    base1 = fifo_cnt[head + PTR_W'(i)];
            end
        end
        new0 = sat_step(base0, upd0_taken_i);
        if (acc0 && (upd0_idx_i == upd1_idx_i))
            base1 = new0;
        new1 = sat_step(base1, upd1_taken_i);
    end

    always_comb begin
        w_obus = '0;
        if (state == INIT)
            w_obus = {1'b1, sweep, INIT_CNT};
        else if (count != '0)
            w_obus = {1'b1, fifo_idx[head], fifo_cnt[head]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            sweep <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case (state)
                INIT: begin
                    sweep <= sweep + ADDR_W'(1);
                    if (sweep == SWEEP_LAST)
                        state <= RUN;
                end
                RUN: begin
                    if (acc0) begin
                        fifo_idx[tail] <= upd0_idx_i;
                        fifo_cnt[tail] <= new0;
                    end
                    // A lone lane 1 takes the first free slot.
                    if (acc1) begin
                        fifo_idx[tail + PTR_W'(acc0)] <= upd1_idx_i;
                        fifo_cnt[tail + PTR_W'(acc0)] <= new1;
                    end
                    tail  <= tail + PTR_W'(acc0) + PTR_W'(acc1);
                    if (pop)
                        head <= head + PTR_W'(1);
                    count <= count + CW'(acc0) + CW'(acc1) - CW'(pop);
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pht_update_unit.sv
// Scoreboard bench for pht_update_unit on a 16-entry build: stimulus pushes expected writes,
// a negedge monitor pops and compares them against the PHT write bus.
module tb_pht_update_unit;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 2;
    localparam int DEPTH  = 4;
    localparam int BUS_W  = 1 + ADDR_W + CNT_W;

    logic              clk;
    logic              rst;
    logic              upd0_valid_i;
    logic [ADDR_W-1:0] upd0_idx_i;
    logic              upd0_taken_i;
    logic [CNT_W-1:0]  upd0_cnt_i;
    logic              upd1_valid_i;
    logic [ADDR_W-1:0] upd1_idx_i;
    logic              upd1_taken_i;
    logic [CNT_W-1:0]  upd1_cnt_i;
    logic              upd_ready_o;
    logic              init_busy_o;
    logic [BUS_W-1:0]  w_obus;

    typedef struct {
        logic [BUS_W-1:0] bus;
        int               avail;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    bit bp_t0[6] = '{1, 1, 1, 0, 1, 1};
    int bp_c0[6] = '{0, 3, 2, 2, 1, 0};
    int bp_e0[6] = '{1, 3, 3, 1, 2, 1};
    bit bp_t1[6] = '{0, 0, 0, 1, 0, 0};
    int bp_c1[6] = '{3, 0, 1, 1, 2, 3};
    int bp_e1[6] = '{2, 0, 0, 2, 1, 2};

    pht_update_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .upd0_valid_i (upd0_valid_i),
        .upd0_idx_i   (upd0_idx_i),
        .upd0_taken_i (upd0_taken_i),
        .upd0_cnt_i   (upd0_cnt_i),
        .upd1_valid_i (upd1_valid_i),
        .upd1_idx_i   (upd1_idx_i),
        .upd1_taken_i (upd1_taken_i),
        .upd1_cnt_i   (upd1_cnt_i),
        .upd_ready_o  (upd_ready_o),
        .init_busy_o  (init_busy_o),
        .w_obus       (w_obus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushExp(input logic [ADDR_W-1:0] idx, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.bus   = {1'b1, idx, cnt};
        e.avail = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Every write on the bus must match the oldest expected entry; a due entry with no write is a miss.
    always @(negedge clk) begin
        if (!rst) begin
            if (w_obus[BUS_W-1]) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'(w_obus), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("write_bus", 32'(w_obus), 32'(mon_e.bus));
                end
            end else if (exp_q.size() != 0 && exp_q[0].avail <= cyc) begin
                mon_e = exp_q.pop_front();
                checkOutput("missing_write", 32'(w_obus), 32'(mon_e.bus));
            end
        end
    end

    task automatic idle(input int n);
        upd0_valid_i = 1'b0;
        upd1_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] i0, input logic t0,
                                 input logic [CNT_W-1:0] c0, input logic v1,
                                 input logic [ADDR_W-1:0] i1, input logic t1,
                                 input logic [CNT_W-1:0] c1);
        upd0_valid_i = v0;
        upd0_idx_i   = i0;
        upd0_taken_i = t0;
        upd0_cnt_i   = c0;
        upd1_valid_i = v1;
        upd1_idx_i   = i1;
        upd1_taken_i = t1;
        upd1_cnt_i   = c1;
        @(posedge clk);
        #1;
        upd0_valid_i = 1'b0;
        upd1_valid_i = 1'b0;
    endtask

    task automatic waitReady();
        int n = 0;
        while (!upd_ready_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!upd_ready_o)
            checkOutput("ready_timeout", 32'(upd_ready_o), 32'd1);
    endtask

    // One reset cycle, then the full sweep: 16 writes of 1 to indices 0..15, then idle in RUN.
    task automatic doReset();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < (1 << ADDR_W); i++)
            pushExp(ADDR_W'(i), CNT_W'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            checkOutput("init_busy", 32'(init_busy_o), 32'd1);
            checkOutput("init_ready", 32'(upd_ready_o), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("run_busy", 32'(init_busy_o), 32'd0);
        checkOutput("run_ready", 32'(upd_ready_o), 32'd1);
        checkOutput("run_idle_we", 32'(w_obus[BUS_W-1]), 32'd0);
    endtask

    initial begin
        int mc;
        int k;
        bit exp_rdy;
        upd0_valid_i = 1'b0; upd0_idx_i = '0; upd0_taken_i = 1'b0; upd0_cnt_i = '0;
        upd1_valid_i = 1'b0; upd1_idx_i = '0; upd1_taken_i = 1'b0; upd1_cnt_i = '0;
        doReset();

        $display("[TB] single updates");
        waitReady(); pushExp(5, 2); applyStimulus(1, 5, 1, 1, 0, 0, 0, 0); idle(3);
        waitReady(); pushExp(5, 3); applyStimulus(1, 5, 1, 3, 0, 0, 0, 0); idle(3);
        waitReady(); pushExp(5, 0); applyStimulus(1, 5, 0, 0, 0, 0, 0, 0); idle(3);

        $display("[TB] head being popped still corrects");
        waitReady(); pushExp(3, 2); applyStimulus(1, 3, 1, 1, 0, 0, 0, 0);
        pushExp(3, 3); applyStimulus(1, 3, 1, 0, 0, 0, 0, 0); idle(3);

        $display("[TB] same-cycle collision");
        waitReady(); pushExp(7, 2); pushExp(7, 3); applyStimulus(1, 7, 1, 1, 1, 7, 1, 1); idle(4);

        $display("[TB] in-flight correction behind backpressure");
        waitReady();
        pushExp(10, 2); pushExp(11, 1); applyStimulus(1, 10, 1, 1, 1, 11, 1, 0);
        pushExp(12, 1); pushExp(9, 2);  applyStimulus(1, 12, 0, 2, 1, 9, 0, 3);
        checkOutput("ready_drop", 32'(upd_ready_o), 32'd0);
        waitReady();
        pushExp(9, 1); pushExp(9, 0); applyStimulus(1, 9, 0, 0, 1, 9, 0, 0);
        idle(6);

        $display("[TB] sustained dual-lane backpressure");
        mc = 0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            exp_rdy = (mc <= 2);
            checkOutput("bp_ready", 32'(upd_ready_o), 32'(exp_rdy));
            if (k < 6) begin
                upd0_valid_i = 1'b1; upd0_idx_i = ADDR_W'(2 * k);
                upd0_taken_i = bp_t0[k]; upd0_cnt_i = CNT_W'(bp_c0[k]);
                upd1_valid_i = 1'b1; upd1_idx_i = ADDR_W'(2 * k + 1);
                upd1_taken_i = bp_t1[k]; upd1_cnt_i = CNT_W'(bp_c1[k]);
                if (upd_ready_o) begin
                    pushExp(ADDR_W'(2 * k), CNT_W'(bp_e0[k]));
                    pushExp(ADDR_W'(2 * k + 1), CNT_W'(bp_e1[k]));
                    k++;
                end
            end else begin
                upd0_valid_i = 1'b0;
                upd1_valid_i = 1'b0;
            end
            mc = mc + (exp_rdy ? 2 : 0) - ((mc > 0) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        checkOutput("bp_pairs_accepted", 32'(k), 32'd6);
        idle(8);

        $display("[TB] reset with queued entries");
        waitReady();
        pushExp(1, 2); pushExp(2, 1); applyStimulus(1, 1, 1, 1, 1, 2, 0, 2);
        pushExp(3, 3); pushExp(4, 0); applyStimulus(1, 3, 1, 2, 1, 4, 0, 1);
        doReset();
        idle(6);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
